// File: rtl/block_lane_controller_if.sv
// block_lane_controller_if
// Bundles the game-flow commands and the renderer/score outputs of the
// obstacle lane so the controller and its consumers share one port.
// Signals (named from the controller's point of view):
//   start_i        leave the idle shuffle and arm the lane
//   squareReady_i  player square in position, begin scrolling
//   pause_i        level-sensitive scroll hold
//   over_i         game over, freeze everything until reset
//   blockShape_o   packed shapes, block i at [i*SHAPE_W +: SHAPE_W]
//   blockStartX_o  packed left-edge X, block i at [i*COORD_W +: COORD_W]
//   blockColor_o   packed colours, block i at [i*COLOR_W +: COLOR_W]
//   speed_o        pixels moved per motion tick
//   score_o        count of wrapped blocks, saturating
//   blockPassed_o  one-cycle pulse whenever any block wraps
//   moving_o       high while the lane scrolls
interface block_lane_controller_if #(
  parameter int N_BLOCKS = 4,
  parameter int SHAPE_W  = 4,
  parameter int COLOR_W  = 3,
  parameter int COORD_W  = 10
);
  logic                         start_i;
  logic                         squareReady_i;
  logic                         pause_i;
  logic                         over_i;
  logic [N_BLOCKS*SHAPE_W-1:0]  blockShape_o;
  logic [N_BLOCKS*COORD_W-1:0]  blockStartX_o;
  logic [N_BLOCKS*COLOR_W-1:0]  blockColor_o;
  logic [3:0]                   speed_o;
  logic [15:0]                  score_o;
  logic                         blockPassed_o;
  logic                         moving_o;

  modport master (
    output start_i, squareReady_i, pause_i, over_i,
    input  blockShape_o, blockStartX_o, blockColor_o,
           speed_o, score_o, blockPassed_o, moving_o
  );

  modport slave (
    input  start_i, squareReady_i, pause_i, over_i,
    output blockShape_o, blockStartX_o, blockColor_o,
           speed_o, score_o, blockPassed_o, moving_o
  );
endinterface

// File: rtl/block_lane_controller.sv
// block_lane_controller
// Drives N_BLOCKS obstacles across a circular lane: idle shuffle, arming,
// scrolling, pausing and a game-over freeze. A free-running divider makes
// the motion tick; a Galois LFSR supplies new shapes/colours whenever a
// block wraps; scroll speed rises every LEVEL_TICKS scrolling ticks.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, clears all state
//   bus  block_lane_controller_if.slave (commands in, packed buses out)
module block_lane_controller #(
  parameter int N_BLOCKS    = 4,
  parameter int SHAPE_W     = 4,
  parameter int COLOR_W     = 3,
  parameter int COORD_W     = 10,
  parameter int TICK_DIV    = 1000000,
  parameter int SPACING     = 160,
  parameter int SPEED_INIT  = 2,
  parameter int SPEED_MAX   = 8,
  parameter int LEVEL_TICKS = 500
) (
  input  logic                     clk,
  input  logic                     rst,
  block_lane_controller_if.slave   bus
);
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int LEVEL_W = $clog2(LEVEL_TICKS + 1);

  localparam logic [2:0] ST_SHUFFLE = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_SCROLL  = 3'd2;
  localparam logic [2:0] ST_PAUSED  = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  localparam logic [COORD_W:0] LANE_LEN  = (COORD_W + 1)'(N_BLOCKS * SPACING);

  logic [2:0]          stateQ, stateD;
  logic [TICK_W-1:0]   tickCntQ;
  logic [15:0]         lfsrQ;
  logic [COORD_W-1:0]  xQ     [N_BLOCKS];
  logic [COORD_W-1:0]  xD     [N_BLOCKS];
  logic [SHAPE_W-1:0]  shapeQ [N_BLOCKS];
  logic [SHAPE_W-1:0]  shapeD [N_BLOCKS];
  logic [COLOR_W-1:0]  colorQ [N_BLOCKS];
  logic [COLOR_W-1:0]  colorD [N_BLOCKS];
  logic [3:0]          speedQ, speedD;
  logic [15:0]         scoreQ, scoreD;
  logic                passedQ, passedD;
  logic [LEVEL_W-1:0]  levelQ, levelD, levelInc;

  logic                tick;
  logic [COORD_W:0]    speedExt;
  logic [COORD_W:0]    xExt;
  logic [3:0]          wrapCnt;
  logic [16:0]         scoreSum;

  logic [N_BLOCKS*SHAPE_W-1:0] shapeBus;
  logic [N_BLOCKS*COORD_W-1:0] xBus;
  logic [N_BLOCKS*COLOR_W-1:0] colorBus;

  // Each block sees the shared LFSR rotated by a different amount so that
  // blocks reloaded on the same tick still get different shapes/colours.
  function automatic logic [15:0] laneSeed(input logic [15:0] l, input int idx);
    int rot;
    rot = (3 * idx) % 16;
    return (l << rot) | (l >> (16 - rot));
  endfunction

  function automatic logic [SHAPE_W-1:0] drawShape(input logic [15:0] l, input int idx);
    logic [15:0] s;
    s = laneSeed(l, idx);
    return s[SHAPE_W-1:0];
  endfunction

  // Colour 0 is the renderer's background, so it is never handed out.
  function automatic logic [COLOR_W-1:0] drawColor(input logic [15:0] l, input int idx);
    logic [15:0]        s;
    logic [COLOR_W-1:0] c;
    s = laneSeed(l, idx);
    c = s[8 +: COLOR_W];
    return (c == '0) ? COLOR_W'(1) : c;
  endfunction

  assign tick     = (tickCntQ == TICK_W'(TICK_DIV - 1));
  assign speedExt = (COORD_W + 1)'(speedQ);

  // OVER beats everything; the remaining commands only matter in the one
  // state that listens for them.
  always_comb begin
    stateD = stateQ;
    if (bus.over_i) begin
      stateD = ST_HALT;
    end else begin
      case (stateQ)
        ST_SHUFFLE: if (bus.start_i)       stateD = ST_ARMED;
        ST_ARMED:   if (bus.squareReady_i) stateD = ST_SCROLL;
        ST_SCROLL:  if (bus.pause_i)       stateD = ST_PAUSED;
        ST_PAUSED:  if (!bus.pause_i)      stateD = ST_SCROLL;
        default:                           stateD = stateQ;
      endcase
    end
  end

  // Motion keys off the pre-edge state, so a tick that coincides with
  // PAUSE or OVER still moves the lane once. The speed bump is applied
  // after this tick's motion has used the old speed.
  always_comb begin
    xD       = xQ;
    shapeD   = shapeQ;
    colorD   = colorQ;
    scoreD   = scoreQ;
    speedD   = speedQ;
    levelD   = levelQ;
    passedD  = 1'b0;
    wrapCnt  = '0;
    xExt     = '0;
    scoreSum = '0;
    levelInc = '0;
    if (tick && stateQ == ST_SCROLL) begin
      for (int i = 0; i < N_BLOCKS; i++) begin
        xExt = {1'b0, xQ[i]};
        if (xExt >= speedExt) begin
          xD[i] = COORD_W'(xExt - speedExt);
        end else begin
          xD[i]     = COORD_W'(xExt + LANE_LEN - speedExt);
          shapeD[i] = drawShape(lfsrQ, i);
          colorD[i] = drawColor(lfsrQ, i);
          wrapCnt   = wrapCnt + 4'd1;
        end
      end
      scoreSum = {1'b0, scoreQ} + 17'(wrapCnt);
      scoreD   = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
      passedD  = (wrapCnt != 4'd0);
      levelInc = levelQ + 1'b1;
      if (levelInc == LEVEL_W'(LEVEL_TICKS)) begin
        levelD = '0;
        if (speedQ < 4'(SPEED_MAX)) speedD = speedQ + 4'd1;
      end else begin
        levelD = levelInc;
      end
    end else if (tick && stateQ == ST_SHUFFLE) begin
      for (int i = 0; i < N_BLOCKS; i++) begin
        shapeD[i] = drawShape(lfsrQ, i);
        colorD[i] = drawColor(lfsrQ, i);
      end
    end
  end

  // Divider and LFSR run in every state, including HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= ST_SHUFFLE;
      tickCntQ <= '0;
      lfsrQ    <= LFSR_SEED;
      speedQ   <= 4'(SPEED_INIT);
      scoreQ   <= '0;
      passedQ  <= 1'b0;
      levelQ   <= '0;
      for (int i = 0; i < N_BLOCKS; i++) begin
        xQ[i]     <= COORD_W'(i * SPACING);
        shapeQ[i] <= SHAPE_W'(i);
        colorQ[i] <= COLOR_W'(1);
      end
    end else begin
      stateQ   <= stateD;
      tickCntQ <= tick ? '0 : tickCntQ + 1'b1;
      lfsrQ    <= lfsrQ[0] ? ((lfsrQ >> 1) ^ LFSR_MASK) : (lfsrQ >> 1);
      speedQ   <= speedD;
      scoreQ   <= scoreD;
      passedQ  <= passedD;
      levelQ   <= levelD;
      xQ       <= xD;
      shapeQ   <= shapeD;
      colorQ   <= colorD;
    end
  end

  always_comb begin
    shapeBus = '0;
    xBus     = '0;
    colorBus = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      shapeBus[i*SHAPE_W +: SHAPE_W] = shapeQ[i];
      xBus[i*COORD_W +: COORD_W]     = xQ[i];
      colorBus[i*COLOR_W +: COLOR_W] = colorQ[i];
    end
  end

  assign bus.blockShape_o  = shapeBus;
  assign bus.blockStartX_o = xBus;
  assign bus.blockColor_o  = colorBus;
  assign bus.speed_o       = speedQ;
  assign bus.score_o       = scoreQ;
  assign bus.blockPassed_o = passedQ;
  assign bus.moving_o      = (stateQ == ST_SCROLL);
endmodule
